// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks.
//   rx_state_e  - receiver FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   DEF_*       - default frame format and baud divider (100 MHz, 19200 baud, 16x)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int DEF_DVSR    = 326;
    localparam int DEF_DVSR_W  = 9;

endpackage

// File: rtl/baud_gen.sv
// baud_gen: free-running mod-DVSR counter producing the 16x oversampling tick.
//   clk    - system clock
//   reset  - synchronous, active-high reset (count returns to 0)
//   s_tick - one-cycle pulse while the count sits at DVSR-1
// DVSR_W must be wide enough to hold DVSR-1.
module baud_gen #(
    parameter int DVSR   = 326,
    parameter int DVSR_W = 9
) (
    input  logic clk,
    input  logic reset,
    output logic s_tick
);

    localparam logic [DVSR_W-1:0] LAST = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DVSR_W'(1);
        end
    end

    assign s_tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling 8N1 serial receiver feeding the receive FIFO.
//   clk          - system clock
//   reset        - synchronous, active-high reset; discards any partial frame
//   rx           - asynchronous serial input, idles high
//   dout         - last correctly framed byte; untouched by errors and glitches
//   rx_done_tick - one-cycle strobe, dout valid this cycle (FIFO write)
//   frame_err    - one-cycle strobe, stop bit sampled low (byte not written)
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int DVSR    = DEF_DVSR,
    parameter int DVSR_W  = DEF_DVSR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int N_W         = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int SYNC_STAGES = 2;

    localparam logic [N_W-1:0] N_LAST    = N_W'(DBIT - 1);
    localparam logic [3:0]     STOP_LAST = 4'(SB_TICK - 1);

    logic                   s_tick;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    rx_state_e              state_reg;
    logic [3:0]             s_reg;
    logic [N_W-1:0]         n_reg;
    logic [DBIT-1:0]        b_reg;

    baud_gen #(
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick)
    );

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Start edge is taken without waiting for a tick.
                    if (!rx_s) begin
                        state_reg <= START;
                        s_reg     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_reg == 4'd7) begin
                            // Mid-start-bit: a high line here means a glitch.
                            if (!rx_s) begin
                                state_reg <= DATA;
                                s_reg     <= '0;
                                n_reg     <= '0;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            s_reg <= s_reg + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_reg == 4'd15) begin
                            s_reg <= '0;
                            b_reg <= {rx_s, b_reg[DBIT-1:1]};
                            if (n_reg == N_LAST) begin
                                state_reg <= STOP;
                            end else begin
                                n_reg <= n_reg + N_W'(1);
                            end
                        end else begin
                            s_reg <= s_reg + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_reg == STOP_LAST) begin
                            // Leave at mid-stop so a back-to-back start edge
                            // is seen from IDLE.
                            state_reg <= IDLE;
                            if (rx_s) begin
                                dout         <= b_reg;
                                rx_done_tick <= 1'b1;
                            end else begin
                                frame_err    <= 1'b1;
                            end
                        end else begin
                            s_reg <= s_reg + 4'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with DVSR = 4 (64 clk per bit).
// Each driven frame pushes its expected outcome; the monitor pops one entry
// per strobe and compares strobe kind and dout.
module tb_uart_rx;

    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int DVSR     = 4;
    localparam int DVSR_W   = 2;
    localparam int BIT_CLKS = 16 * DVSR;

    logic            clk = 1'b0;
    logic            reset;
    logic            rx;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;

    typedef struct packed {
        logic            is_err;
        logic [DBIT-1:0] data;
    } exp_t;

    exp_t            exp_q[$];
    int              checks    = 0;
    int              failures  = 0;
    int              done_cnt  = 0;
    int              err_cnt   = 0;
    logic [DBIT-1:0] last_good = '0;

    uart_rx #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .DVSR    (DVSR),
        .DVSR_W  (DVSR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: one scoreboard pop per strobe cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && (rx_done_tick || frame_err)) begin
            check("strobe_exclusive", 32'(rx_done_tick & frame_err), 32'd0);
            if (rx_done_tick) done_cnt++;
            if (frame_err)    err_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(frame_err), 32'(e.is_err));
                check("dout", 32'(dout), 32'(e.data));
                $display("RX %s dout=0x%02h expected=0x%02h",
                         frame_err ? "frame_err" : "byte", dout, e.data);
            end
        end
    end

    task automatic drive_bit(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DBIT-1:0] data, input logic stop_val, input int stop_clks);
        exp_t e;
        if (stop_val) begin
            e.is_err  = 1'b0;
            e.data    = data;
            last_good = data;
        end else begin
            e.is_err  = 1'b1;
            e.data    = last_good;
        end
        exp_q.push_back(e);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < DBIT; i++) drive_bit(data[i], BIT_CLKS);
        drive_bit(stop_val, stop_clks);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] mid_byte;
        rx    = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_done", 32'(rx_done_tick), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;

        // Idle line for 10 bit times.
        repeat (10 * BIT_CLKS) @(negedge clk);
        check("idle_strobes", 32'(done_cnt + err_cnt), 32'd0);
        check("idle_dout", 32'(dout), 32'd0);

        // Single valid byte.
        send_frame(8'h55, 1'b1, BIT_CLKS);
        wait_drain("t55_drain");
        check("t55_done_cnt", 32'(done_cnt), 32'd1);
        check("t55_err_cnt", 32'(err_cnt), 32'd0);

        // Back-to-back bytes, no idle gap.
        send_frame(8'hA3, 1'b1, BIT_CLKS);
        send_frame(8'h0F, 1'b1, BIT_CLKS);
        wait_drain("b2b_drain");
        check("b2b_done_cnt", 32'(done_cnt), 32'd3);

        // Start glitch: 5 ticks low, then high.
        drive_bit(1'b0, 5 * DVSR);
        drive_bit(1'b1, BIT_CLKS);
        check("glitch_state", 32'(dut.state_reg), 32'd0);
        check("glitch_strobes", 32'(done_cnt + err_cnt), 32'd3);
        send_frame(8'h3C, 1'b1, BIT_CLKS);
        wait_drain("post_glitch_drain");
        check("post_glitch_dout", 32'(dout), 32'h3C);

        // Framing error: stop held low for 3/4 bit; the restart it causes
        // sees a high line at mid-start and is dropped as a glitch.
        send_frame(8'hFF, 1'b0, 48);
        drive_bit(1'b1, 2 * BIT_CLKS);
        wait_drain("ferr_drain");
        check("ferr_err_cnt", 32'(err_cnt), 32'd1);
        check("ferr_done_cnt", 32'(done_cnt), 32'd4);
        check("ferr_dout_kept", 32'(dout), 32'h3C);
        check("ferr_state", 32'(dut.state_reg), 32'd0);

        // Reset during data bit 4 of 0x81; the partial frame is abandoned.
        mid_byte = 8'h81;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(mid_byte[i], BIT_CLKS);
        drive_bit(mid_byte[4], BIT_CLKS / 2);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_done", 32'(rx_done_tick), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        check("midrst_state", 32'(dut.state_reg), 32'd0);
        reset = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("midrst_no_strobe", 32'(done_cnt + err_cnt), 32'd5);
        send_frame(8'h81, 1'b1, BIT_CLKS);
        wait_drain("post_rst_drain");
        check("post_rst_dout", 32'(dout), 32'h81);

        repeat (BIT_CLKS) @(negedge clk);
        check("final_done_cnt", 32'(done_cnt), 32'd5);
        check("final_err_cnt", 32'(err_cnt), 32'd1);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
